// File: rtl/ext_serial_scheduler_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// ext_serial_scheduler_pkg: shared types and mode-bit indices for the
// ext serial scheduler.  Revision: 1.0
// ------------------------------------------------------------------------
package ext_serial_scheduler_pkg;

  typedef logic       Bit_t;
  typedef logic [7:0] Byte_t;
  typedef logic [1:0] Serial_mode_t;

  localparam int SER_MODE_TX_IDLE  = 0;
  localparam int SER_MODE_RX_READY = 1;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_ISSUE     = 2'd1,
    TX_WAIT_BUSY = 2'd2,
    TX_WAIT_DONE = 2'd3
  } Serial_tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_STROBE  = 2'd1,
    RX_CAPTURE = 2'd2,
    RX_SETTLE  = 2'd3
  } Serial_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/ext_serial_scheduler_fifo.sv
`default_nettype none
// ------------------------------------------------------------------------
// serial_fifo: synchronous first-word-fall-through byte FIFO, 2**AW deep.
// Revision: 1.0
// ------------------------------------------------------------------------
module serial_fifo #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [7:0]  wdata_i,
  output logic [7:0]  rdata_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] level_o
);
  localparam int DEPTH = 1 << AW;

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit, so the difference is the exact occupancy.
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = level_o[AW];
  assign empty_o = (level_o == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/ext_serial_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------------
// ext_serial_scheduler: TX/RX byte FIFOs plus write_op/read_op sequencing
// for the external UART byte controller.  Revision: 1.0
// ------------------------------------------------------------------------
module ext_serial_scheduler
  import ext_serial_scheduler_pkg::*;
#(
  parameter int TX_AW        = 4,
  parameter int RX_AW        = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_push_i,
  input  logic [7:0]       tx_data_i,
  output logic             tx_full_o,
  output logic [TX_AW:0]   tx_level_o,
  input  logic             rx_pop_i,
  output logic [7:0]       rx_data_o,
  output logic             rx_empty_o,
  output logic [RX_AW:0]   rx_level_o,
  output logic             rx_overrun_o,
  input  logic             ovr_clear_i,
  output logic             ser_write_op_o,
  output logic             ser_read_op_o,
  output logic [7:0]       ser_data_out_o,
  input  logic [7:0]       ser_data_in_i,
  input  logic [1:0]       ser_mode_i
);
  localparam int               CNT_W    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

  Serial_tx_state_t tx_state_q, tx_state_d;
  Serial_rx_state_t rx_state_q, rx_state_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             overrun_q, overrun_d;

  logic       tx_pop;
  logic       tx_empty;
  logic [7:0] tx_head;
  logic       rx_push;
  logic       rx_full;
  logic       tx_idle;
  logic       rx_ready;

  assign tx_idle  = ser_mode_i[SER_MODE_TX_IDLE];
  assign rx_ready = ser_mode_i[SER_MODE_RX_READY];

  serial_fifo #(.AW(TX_AW)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tx_push_i),
    .pop_i   (tx_pop),
    .wdata_i (tx_data_i),
    .rdata_o (tx_head),
    .full_o  (tx_full_o),
    .empty_o (tx_empty),
    .level_o (tx_level_o)
  );

  serial_fifo #(.AW(RX_AW)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_push),
    .pop_i   (rx_pop_i),
    .wdata_i (ser_data_in_i),
    .rdata_o (rx_data_o),
    .full_o  (rx_full),
    .empty_o (rx_empty_o),
    .level_o (rx_level_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      busy_cnt_q <= '0;
      data_out_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      busy_cnt_q <= busy_cnt_d;
      data_out_q <= data_out_d;
      overrun_q  <= overrun_d;
    end
  end

  // A controller that never reports busy must not wedge the queue: give up after the timeout.
  always_comb begin
    tx_state_d = tx_state_q;
    busy_cnt_d = busy_cnt_q;
    data_out_d = data_out_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty && tx_idle) begin
          tx_pop     = 1'b1;
          data_out_d = tx_head;
          tx_state_d = TX_ISSUE;
        end
      end
      TX_ISSUE: begin
        busy_cnt_d = '0;
        tx_state_d = TX_WAIT_BUSY;
      end
      TX_WAIT_BUSY: begin
        if (!tx_idle)                   tx_state_d = TX_WAIT_DONE;
        else if (busy_cnt_q == CNT_LAST) tx_state_d = TX_IDLE;
        else                            busy_cnt_d = busy_cnt_q + 1'b1;
      end
      TX_WAIT_DONE: begin
        if (tx_idle) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Read strobe fires even with a full RX FIFO so the controller always drains its byte.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_push    = 1'b0;
    overrun_d  = overrun_q;
    if (ovr_clear_i) overrun_d = 1'b0;
    case (rx_state_q)
      RX_IDLE:    if (rx_ready) rx_state_d = RX_STROBE;
      RX_STROBE:  rx_state_d = RX_CAPTURE;
      RX_CAPTURE: begin
        rx_push    = 1'b1;
        if (rx_full) overrun_d = 1'b1;
        rx_state_d = RX_SETTLE;
      end
      RX_SETTLE:  rx_state_d = RX_IDLE;
      default:    rx_state_d = RX_IDLE;
    endcase
  end

  assign ser_write_op_o = (tx_state_q == TX_ISSUE);
  assign ser_read_op_o  = (rx_state_q == RX_STROBE);
  assign ser_data_out_o = data_out_q;
  assign rx_overrun_o   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ext_serial_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_ext_serial_scheduler: directed + randomized bench with a behavioural
// UART-controller model and queue-based FIFO reference.  Revision: 1.0
// ------------------------------------------------------------------------
module tb_ext_serial_scheduler;
  localparam int DEPTH        = 16;
  localparam int BUSY_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_push, rx_pop, ovr_clear;
  logic [7:0] tx_data, ser_data_in;
  logic [1:0] ser_mode;
  logic       tx_full, rx_empty, rx_overrun, ser_write_op, ser_read_op;
  logic [4:0] tx_level, rx_level;
  logic [7:0] rx_data, ser_data_out;

  ext_serial_scheduler dut (
    .clk(clk), .rst(rst),
    .tx_push_i(tx_push), .tx_data_i(tx_data), .tx_full_o(tx_full), .tx_level_o(tx_level),
    .rx_pop_i(rx_pop), .rx_data_o(rx_data), .rx_empty_o(rx_empty), .rx_level_o(rx_level),
    .rx_overrun_o(rx_overrun), .ovr_clear_i(ovr_clear),
    .ser_write_op_o(ser_write_op), .ser_read_op_o(ser_read_op),
    .ser_data_out_o(ser_data_out), .ser_data_in_i(ser_data_in), .ser_mode_i(ser_mode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] sent_q[$];
  int         sent_cyc[$];
  logic [7:0] rx_pend[$];
  logic [7:0] rx_model[$];
  logic       exp_ovr = 1'b0;
  int         n_deliv = 0;
  int         n_rd = 0;
  bit         hold_busy = 1'b1;
  bit         nobusy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Controller model: busy from 2 cycles after write_op for 20 cycles; ready held until read_op.
  initial begin
    int  tx_cnt;
    int  gap;
    bit  rdy;
    tx_cnt = 0; gap = 0; rdy = 1'b0;
    ser_mode = 2'b00; ser_data_in = 8'h00;
    forever begin
      @(negedge clk);
      if (ser_write_op === 1'b1) begin
        chk("tx_one_per_frame", tx_cnt, 0);
        sent_q.push_back(ser_data_out);
        sent_cyc.push_back(cyc);
        if (!nobusy) tx_cnt = 23;
      end
      if (tx_cnt > 0) tx_cnt--;
      if (ser_read_op === 1'b1) begin
        n_rd++;
        chk("rx_strobe_when_ready", {31'd0, rdy}, 1);
        if (rx_model.size() < DEPTH) rx_model.push_back(ser_data_in);
        else exp_ovr = 1'b1;
        n_deliv++;
        rdy = 1'b0;
        gap = 3;
      end else if (gap > 0) begin
        gap--;
      end else if (!rdy && rx_pend.size() > 0) begin
        ser_data_in = rx_pend.pop_front();
        rdy = 1'b1;
      end
      ser_mode = {rdy, hold_busy ? 1'b0 : !(tx_cnt >= 1 && tx_cnt <= 20)};
    end
  end

  task automatic push_byte(input logic [7:0] b);
    tx_data = b;
    tx_push = 1'b1;
    @(negedge clk);
    tx_push = 1'b0;
  endtask

  task automatic wait_sent(input int n);
    for (int i = 0; i < 3000 && sent_q.size() < n; i++) @(negedge clk);
    chk("tx_sent_count", sent_q.size(), n);
  endtask

  task automatic wait_deliv(input int n);
    for (int i = 0; i < 3000 && n_deliv < n; i++) @(negedge clk);
    chk("rx_deliv_count", n_deliv, n);
    repeat (6) @(negedge clk);
  endtask

  task automatic compare_tx();
    while (exp_tx.size() > 0 && sent_q.size() > 0)
      chk("tx_data_order", sent_q.pop_front(), exp_tx.pop_front());
    chk("tx_leftover", exp_tx.size() + sent_q.size(), 0);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    e = rx_model.pop_front();
    chk(tag, rx_data, e);
    rx_pop = 1'b1;
    @(negedge clk);
    rx_pop = 1'b0;
  endtask

  initial begin
    int base;
    int n;
    logic [7:0] b;
    rst = 1'b1; tx_push = 1'b0; rx_pop = 1'b0; ovr_clear = 1'b0; tx_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_write_op", ser_write_op, 0);
    chk("rst_read_op", ser_read_op, 0);
    chk("rst_data_out", ser_data_out, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_overrun", rx_overrun, 0);
    rst = 1'b0;

    // Three bytes queued while controller busy, then released.
    foreach (exp_tx[i]) ;
    push_byte(8'h41); exp_tx.push_back(8'h41);
    push_byte(8'h42); exp_tx.push_back(8'h42);
    push_byte(8'h43); exp_tx.push_back(8'h43);
    chk("tx_level_3", tx_level, 3);
    hold_busy = 1'b0;
    wait_sent(3);
    chk("tx_level_drained", tx_level, 0);
    compare_tx();
    repeat (30) @(negedge clk);

    // Overfill TX FIFO: the 17th push is dropped.
    hold_busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (exp_tx.size() < DEPTH) exp_tx.push_back(b);
      push_byte(b);
      if (i == 14) chk("tx_not_full_15", tx_full, 0);
      if (i == 15) chk("tx_full_16", tx_full, 1);
    end
    chk("tx_level_16", tx_level, 16);
    hold_busy = 1'b0;
    wait_sent(16);
    chk("tx_level_after_16", tx_level, 0);
    compare_tx();
    repeat (30) @(negedge clk);

    // Controller never goes busy: scheduler times out and moves to the next byte.
    hold_busy = 1'b1; nobusy = 1'b1;
    repeat (2) @(negedge clk);
    sent_cyc.delete();
    push_byte(8'hA1); exp_tx.push_back(8'hA1);
    push_byte(8'hB2); exp_tx.push_back(8'hB2);
    hold_busy = 1'b0;
    wait_sent(2);
    if (sent_cyc.size() >= 2) chk("tx_timeout_gap", sent_cyc[1] - sent_cyc[0], BUSY_TIMEOUT + 2);
    compare_tx();
    repeat (15) @(negedge clk);
    nobusy = 1'b0;
    repeat (5) @(negedge clk);

    // Single received byte: timing of strobe and data visibility.
    base = n_rd;
    rx_pend.push_back(8'h5A);
    for (int i = 0; i < 100 && ser_read_op !== 1'b1; i++) @(negedge clk);
    chk("rx_strobe_seen", ser_read_op, 1);
    chk("rx_empty_at_strobe", rx_empty, 1);
    @(negedge clk);
    chk("rx_strobe_one_cycle", ser_read_op, 0);
    chk("rx_empty_capture", rx_empty, 1);
    @(negedge clk);
    chk("rx_empty_fell", rx_empty, 0);
    pop_check("rx_data_5a");
    chk("rx_empty_after_pop", rx_empty, 1);
    repeat (10) @(negedge clk);
    chk("rx_single_strobe", n_rd - base, 1);

    // 17 bytes without popping: overrun, clear, order intact.
    base = n_deliv;
    for (int i = 0; i < 17; i++) rx_pend.push_back(8'($urandom));
    wait_deliv(base + 17);
    chk("rx_level_16", rx_level, rx_model.size());
    chk("rx_overrun_set", rx_overrun, exp_ovr);
    ovr_clear = 1'b1;
    @(negedge clk);
    ovr_clear = 1'b0;
    chk("rx_overrun_clr", rx_overrun, 0);
    exp_ovr = 1'b0;
    while (rx_model.size() > 0) pop_check("rx_pop_order");
    chk("rx_empty_final", rx_empty, 1);

    // Randomized traffic on both directions.
    for (int r = 0; r < 4; r++) begin
      base = n_deliv;
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) rx_pend.push_back(8'($urandom));
      for (int i = 0; i < $urandom_range(1, 10); i++) begin
        b = 8'($urandom);
        exp_tx.push_back(b);
        push_byte(b);
        repeat ($urandom_range(0, 30)) @(negedge clk);
      end
      wait_sent(exp_tx.size());
      compare_tx();
      wait_deliv(base + n);
      chk("rx_rand_level", rx_level, rx_model.size());
      while (rx_model.size() > 0) pop_check("rx_rand_data");
      repeat (30) @(negedge clk);
    end

    // Reset mid-frame with bytes still queued.
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      exp_tx.push_back(b);
      push_byte(b);
    end
    wait_sent(1);
    repeat (5) @(negedge clk);
    chk("tx_level_5", tx_level, 5);
    chk("tx_first_before_rst", sent_q.pop_front(), exp_tx.pop_front());
    exp_tx.delete();
    #2 rst = 1'b1;
    #1;
    chk("arst_tx_level", tx_level, 0);
    chk("arst_write_op", ser_write_op, 0);
    chk("arst_data_out", ser_data_out, 0);
    chk("arst_tx_full", tx_full, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("no_tx_after_rst", sent_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
